mem_system_ctrl: RTL

- Cache-controller FSM between the processor fetch/memory stage and the cache-plus-banked-memory pair.
- Hits complete in the request cycle.
- Misses run write-back (if the line is dirty), then a line fill from the four-bank memory, then a retry that completes the access.
- Produces the `Done`, `Stall` and `CacheHit` handshake that the memory stage and the performance bench consume.

---
 rtl/mem_system_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_system_ctrl.sv
// ============================================================================
// mem_system_ctrl - cache controller FSM: hit, write-back, 4-word line fill,
// retry. Optional statistics counters under `MEM_SYSTEM_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_system_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        c_enable,
  output logic        c_comp,
  output logic        c_write,
  output logic        c_valid_in,
  output logic [4:0]  c_tag,
  output logic [7:0]  c_index,
  output logic [2:0]  c_offset,
  output logic [15:0] c_data_in,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic [4:0]  c_tag_out,
  input  logic [15:0] c_data_out,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [15:0] m_data_out,
  output logic [15:0] stat_req,
  output logic [15:0] stat_hit
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WB0   = 4'd1;
  localparam logic [3:0] S_WB1   = 4'd2;
  localparam logic [3:0] S_WB2   = 4'd3;
  localparam logic [3:0] S_WB3   = 4'd4;
  localparam logic [3:0] S_RD0   = 4'd5;
  localparam logic [3:0] S_RD1   = 4'd6;
  localparam logic [3:0] S_RD2   = 4'd7;
  localparam logic [3:0] S_RD3   = 4'd8;
  localparam logic [3:0] S_WAIT0 = 4'd9;
  localparam logic [3:0] S_WAIT1 = 4'd10;
  localparam logic [3:0] S_RETRY = 4'd11;
  // First install cycle: the word read in RD0 lands MEM_LAT cycles later.
  localparam logic [3:0] S_FILL0 = 4'(S_RD0 + MEM_LAT);

  logic [3:0]  state, state_nxt;
  logic [4:0]  cap_tag, victim_tag;
  logic [7:0]  cap_index;
  logic [2:0]  cap_offset;
  logic [15:0] cap_data;
  logic        cap_wr;

  logic req_ok, req_bad, idle_hit, idle_miss;
  logic [1:0] wb_word, rd_word, fill_word;

  assign req_ok    = (Rd ^ Wr) & ~Addr[0];
  assign req_bad   = (Rd | Wr) & (Addr[0] | (Rd & Wr));
  assign idle_hit  = c_hit & c_valid;
  assign idle_miss = req_ok & ~idle_hit;
  assign wb_word   = 2'(state - S_WB0);
  assign rd_word   = 2'(state - S_RD0);
  assign fill_word = 2'(state - S_FILL0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_tag    <= '0;
      victim_tag <= '0;
      cap_index  <= '0;
      cap_offset <= '0;
      cap_data   <= '0;
      cap_wr     <= 1'b0;
    end else if (state == S_IDLE && idle_miss) begin
      cap_tag    <= Addr[15:11];
      cap_index  <= Addr[10:3];
      cap_offset <= Addr[2:0];
      cap_data   <= DataIn;
      cap_wr     <= Wr;
      victim_tag <= c_tag_out;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = !idle_miss ? S_IDLE : ((c_valid & c_dirty) ? S_WB0 : S_RD0);
      S_WB0:   state_nxt = S_WB1;
      S_WB1:   state_nxt = S_WB2;
      S_WB2:   state_nxt = S_WB3;
      S_WB3:   state_nxt = S_RD0;
      S_RD0:   state_nxt = S_RD1;
      S_RD1:   state_nxt = S_RD2;
      S_RD2:   state_nxt = S_RD3;
      S_RD3:   state_nxt = S_WAIT0;
      S_WAIT0: state_nxt = S_WAIT1;
      S_WAIT1: state_nxt = S_RETRY;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high so an aborted fill installs nothing.
  always_comb begin
    DataOut    = '0;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    c_enable   = 1'b0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_valid_in = 1'b0;
    c_tag      = '0;
    c_index    = '0;
    c_offset   = '0;
    c_data_in  = '0;
    m_addr     = '0;
    m_data_in  = '0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (req_bad) begin
            err = 1'b1;
          end else if (req_ok) begin
            c_enable   = 1'b1;
            c_comp     = 1'b1;
            c_write    = Wr;
            c_valid_in = Wr;
            c_tag      = Addr[15:11];
            c_index    = Addr[10:3];
            c_offset   = Addr[2:0];
            c_data_in  = DataIn;
            if (idle_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = c_data_out;
            end else begin
              Stall = 1'b1;
            end
          end
        end
        S_RETRY: begin
          c_enable   = 1'b1;
          c_comp     = 1'b1;
          c_write    = cap_wr;
          c_valid_in = cap_wr;
          c_tag      = cap_tag;
          c_index    = cap_index;
          c_offset   = cap_offset;
          c_data_in  = cap_data;
          Done       = 1'b1;
          DataOut    = c_data_out;
        end
        default: begin
          Stall = 1'b1;
          if (state >= S_WB0 && state <= S_WB3) begin
            c_enable  = 1'b1;
            c_tag     = victim_tag;
            c_index   = cap_index;
            c_offset  = {wb_word, 1'b0};
            m_wr      = 1'b1;
            m_addr    = {victim_tag, cap_index, wb_word, 1'b0};
            m_data_in = c_data_out;
          end
          if (state >= S_RD0 && state <= S_RD3) begin
            m_rd   = 1'b1;
            m_addr = {cap_tag, cap_index, rd_word, 1'b0};
          end
          // The line only becomes valid with its last word.
          if (state >= S_FILL0 && state <= S_WAIT1) begin
            c_enable   = 1'b1;
            c_write    = 1'b1;
            c_tag      = cap_tag;
            c_index    = cap_index;
            c_offset   = {fill_word, 1'b0};
            c_data_in  = m_data_out;
            c_valid_in = (fill_word == 2'd3);
          end
        end
      endcase
    end
  end

`ifdef MEM_SYSTEM_STATS_EN
  logic [15:0] req_cnt, hit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt <= '0;
      hit_cnt <= '0;
    end else begin
      if (Done && req_cnt != 16'hFFFF) req_cnt <= req_cnt + 16'd1;
      if (Done && CacheHit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
    end
  end

  assign stat_req = req_cnt;
  assign stat_hit = hit_cnt;
`else
  assign stat_req = '0;
  assign stat_hit = '0;
`endif

endmodule

`default_nettype wire
